// File: rtl/spi_byte_sequencer_if.sv
// spi_byte_sequencer_if: TX/RX byte streams, SPI master register bus, occupancy and error flag
interface spi_byte_sequencer_if #(parameter int DEPTH = 8);
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready;
  logic rx_valid;
  logic [7:0] rx_data;
  logic rx_ready;
  logic cs;
  logic wr;
  logic rd;
  logic [1:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [$clog2(DEPTH):0] count;
  logic err;
  logic err_clr;
  modport master (
    input tx_valid, tx_data, rx_ready, rdata, err_clr,
    output tx_ready, rx_valid, rx_data, cs, wr, rd, address, wdata, count, err
  );
  modport slave (
    output tx_valid, tx_data, rx_ready, rdata, err_clr,
    input tx_ready, rx_valid, rx_data, cs, wr, rd, address, wdata, count, err
  );
endinterface

// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: buffers TX bytes and runs write/poll/read cycles on the SPI master register bus
module spi_byte_sequencer #(
  parameter int DEPTH = 8,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst,
  spi_byte_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, WRITE, GUARD, POLL, READ} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [15:0] wait_cnt, tmo_cnt;
  logic push, pop;
  assign bus.tx_ready = count != (AW+1)'(DEPTH);
  assign bus.count = count;
  assign push = bus.tx_valid && bus.tx_ready;
  assign pop = state == IDLE && count != '0 && !bus.rx_valid;
  // FIFO storage, written on every accepted TX byte
  always_ff @(posedge clk)
    if (push) mem[wptr] <= bus.tx_data;
  // FIFO pointers and occupancy; pop only happens on the IDLE->WRITE step
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= push ? wptr + 1'b1 : wptr;
      rptr <= pop ? rptr + 1'b1 : rptr;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // Transfer FSM; strobes are set one cycle ahead so they appear registered in the access cycle
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bus.cs <= 1'b0;
      bus.wr <= 1'b0;
      bus.rd <= 1'b0;
      bus.address <= 2'd0;
      bus.wdata <= 8'd0;
      bus.rx_valid <= 1'b0;
      bus.rx_data <= 8'd0;
      bus.err <= 1'b0;
      wait_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      bus.cs <= 1'b0;
      bus.wr <= 1'b0;
      bus.rd <= 1'b0;
      if (bus.rx_ready && bus.rx_valid) bus.rx_valid <= 1'b0;
      if (bus.err_clr) bus.err <= 1'b0;
      case (state)
        IDLE:
          if (pop) begin
            state <= WRITE;
            bus.cs <= 1'b1;
            bus.wr <= 1'b1;
            bus.address <= 2'd0;
            bus.wdata <= mem[rptr];
          end
        WRITE: begin
          state <= GUARD;
          wait_cnt <= '0;
          tmo_cnt <= '0;
        end
        GUARD: begin
          state <= wait_cnt == 16'd1 ? POLL : GUARD;
          wait_cnt <= wait_cnt == 16'd1 ? '0 : wait_cnt + 16'd1;
        end
        POLL: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (tmo_cnt == TMO_LAST) begin
            bus.err <= 1'b1;
            state <= IDLE;
          end else if (bus.rd) begin
            if (!bus.rdata[0]) begin
              state <= READ;
              bus.cs <= 1'b1;
              bus.rd <= 1'b1;
              bus.address <= 2'd0;
            end
          end else if (wait_cnt == GAP_LAST) begin
            bus.cs <= 1'b1;
            bus.rd <= 1'b1;
            bus.address <= 2'd1;
            wait_cnt <= '0;
          end else
            wait_cnt <= wait_cnt + 16'd1;
        end
        READ: begin
          state <= IDLE;
          bus.rx_data <= bus.rdata;
          bus.rx_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
